// File: rtl/exc_arbiter.sv
// Exception/interrupt arbiter in front of CP0: picks the winning event, handshakes
// with CP0, pulses a pipeline flush and tracks nested service levels on a small stack.
module exc_arbiter #(
  parameter int ACK_TIMEOUT = 15,
  parameter int STACK_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  irq_in,
  input  logic [2:0]  irq_mask,
  input  logic [2:0]  exc_cause,
  input  logic [31:0] exc_pc,
  input  logic        stall,
  input  logic        eret,
  input  logic        cp_ack,
  output logic        cp_req,
  output logic [2:0]  cp_cause,
  output logic [1:0]  cp_irq,
  output logic [31:0] cp_ret_addr,
  output logic        flush,
  output logic [1:0]  level,
  output logic        busy,
  output logic [1:0]  err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_SERV  = 2'd3;

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int SW = $clog2(STACK_DEPTH + 1);

  logic [1:0]    state;
  logic [1:0]    ret_state;
  logic [2:0]    irq_prev;
  logic [2:0]    pending;
  logic          exc_pend;
  logic [2:0]    exc_hcause;
  logic [31:0]   exc_hpc;
  logic [TW-1:0] tcnt;
  logic [1:0]    stack [STACK_DEPTH];
  logic [SW-1:0] sp;
  logic          req_exc;

  logic [2:0]  edges;
  logic [2:0]  avail;
  logic        exc_live;
  logic        exc_any;
  logic [2:0]  sel_cause;
  logic [31:0] sel_pc;
  logic        ev_valid;
  logic        ev_exc;
  logic [1:0]  ev_irq;
  logic        can_issue;
  logic        ack_take;
  logic        timeout;
  logic        pop;
  logic [2:0]  clr_mask;

  assign edges     = irq_in & ~irq_prev;
  assign avail     = (pending | edges) & irq_mask;
  assign exc_live  = |exc_cause;
  assign exc_any   = exc_pend | exc_live;
  // An exception held from REQ/FLUSH is older than a live one, so it goes first.
  assign sel_cause = exc_pend ? exc_hcause : exc_cause;
  assign sel_pc    = exc_pend ? exc_hpc : exc_pc;

  always_comb begin
    ev_valid = 1'b0;
    ev_exc   = 1'b0;
    ev_irq   = 2'd0;
    if (exc_any) begin
      ev_valid = 1'b1;
      ev_exc   = 1'b1;
      ev_irq   = 2'd3;
    end else if (avail[2] && level < 2'd3) begin
      ev_valid = 1'b1;
      ev_irq   = 2'd3;
    end else if (avail[1] && level < 2'd2) begin
      ev_valid = 1'b1;
      ev_irq   = 2'd2;
    end else if (avail[0] && level == 2'd0) begin
      ev_valid = 1'b1;
      ev_irq   = 2'd1;
    end
  end

  assign pop       = (state == S_SERV) && eret;
  assign can_issue = ev_valid && !stall &&
                     ((state == S_IDLE) || (state == S_SERV && !eret));
  assign ack_take  = (state == S_REQ) && cp_ack;
  assign timeout   = (state == S_REQ) && !cp_ack &&
                     (tcnt == TW'(ACK_TIMEOUT - 1));

  always_comb begin
    clr_mask = 3'b000;
    if (ack_take && !req_exc && cp_irq != 2'd0)
      clr_mask[cp_irq - 2'd1] = 1'b1;
  end

  assign cp_req = (state == S_REQ);
  assign flush  = (state == S_FLUSH);
  assign busy   = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      ret_state   <= S_IDLE;
      irq_prev    <= 3'b000;
      pending     <= 3'b000;
      exc_pend    <= 1'b0;
      exc_hcause  <= 3'd0;
      exc_hpc     <= 32'd0;
      tcnt        <= '0;
      sp          <= '0;
      req_exc     <= 1'b0;
      level       <= 2'd0;
      err         <= 2'b00;
      cp_cause    <= 3'd0;
      cp_irq      <= 2'd0;
      cp_ret_addr <= 32'd0;
      for (int i = 0; i < STACK_DEPTH; i++)
        stack[i] <= 2'd0;
    end else begin
      irq_prev <= irq_in;
      pending  <= (pending | edges) & ~clr_mask;

      if (ack_take && req_exc)
        exc_pend <= 1'b0;
      if (exc_live && (!exc_pend || (ack_take && req_exc))) begin
        exc_pend   <= 1'b1;
        exc_hcause <= exc_cause;
        exc_hpc    <= exc_pc;
      end

      case (state)
        S_IDLE, S_SERV: begin
          if (pop) begin
            level <= stack[0];
            for (int i = 0; i < STACK_DEPTH - 1; i++)
              stack[i] <= stack[i + 1];
            stack[STACK_DEPTH - 1] <= 2'd0;
            if (sp != '0)
              sp <= sp - SW'(1);
            if (sp <= SW'(1)) begin
              state <= S_IDLE;
              level <= 2'd0;
            end
          end else if (can_issue) begin
            state       <= S_REQ;
            ret_state   <= state;
            tcnt        <= '0;
            req_exc     <= ev_exc;
            cp_irq      <= ev_irq;
            cp_cause    <= ev_exc ? sel_cause : 3'd0;
            cp_ret_addr <= ev_exc ? sel_pc : exc_pc;
          end
        end
        S_REQ: begin
          if (cp_ack) begin
            state    <= S_FLUSH;
            level    <= cp_irq;
            stack[0] <= level;
            for (int i = 1; i < STACK_DEPTH; i++)
              stack[i] <= stack[i - 1];
            if (sp == SW'(STACK_DEPTH))
              err[1] <= 1'b1;
            else
              sp <= sp + SW'(1);
          end else if (timeout) begin
            state  <= ret_state;
            err[0] <= 1'b1;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: state <= S_SERV;
      endcase
    end
  end

endmodule

// File: tb/tb_exc_arbiter.sv
// Bench for exc_arbiter: vector table of single grants plus nesting, stall,
// timeout, overflow and reset sequences, with a queue of expected CP0 requests.
module tb_exc_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  irq_in;
  logic [2:0]  irq_mask;
  logic [2:0]  exc_cause;
  logic [31:0] exc_pc;
  logic        stall;
  logic        eret;
  logic        cp_ack;
  logic        cp_req;
  logic [2:0]  cp_cause;
  logic [1:0]  cp_irq;
  logic [31:0] cp_ret_addr;
  logic        flush;
  logic [1:0]  level;
  logic        busy;
  logic [1:0]  err;

  always #5 clk = ~clk;

  exc_arbiter #(.ACK_TIMEOUT(15), .STACK_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .irq_mask(irq_mask),
    .exc_cause(exc_cause), .exc_pc(exc_pc), .stall(stall), .eret(eret),
    .cp_ack(cp_ack), .cp_req(cp_req), .cp_cause(cp_cause), .cp_irq(cp_irq),
    .cp_ret_addr(cp_ret_addr), .flush(flush), .level(level), .busy(busy),
    .err(err)
  );

  typedef struct {
    logic [2:0]  cause;
    logic [1:0]  irq;
    logic [31:0] addr;
  } exp_t;

  typedef struct {
    string       name;
    logic [2:0]  irq;
    logic [2:0]  mask;
    logic [2:0]  cause;
    logic [31:0] pc;
    int          dly;
    bit          req;
    logic [1:0]  exp_irq;
    logic [1:0]  follow;
  } vec_t;

  localparam logic [31:0] PC_DEF = 32'h100;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    irq_in = 3'b000;
    irq_mask = 3'b111;
    exc_cause = 3'd0;
    exc_pc = PC_DEF;
    stall = 1'b0;
    eret = 1'b0;
    cp_ack = 1'b0;
    exp_q.delete();
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic push_exp(input logic [2:0] c, input logic [1:0] q,
                          input logic [31:0] a);
    exp_t e;
    e.cause = c;
    e.irq = q;
    e.addr = a;
    exp_q.push_back(e);
  endtask

  task automatic pulse_irq(input logic [2:0] b);
    irq_in = b;
    cyc();
    irq_in = 3'b000;
  endtask

  task automatic eret_pulse();
    eret = 1'b1;
    cyc();
    eret = 1'b0;
  endtask

  task automatic watch_quiet(input string name, input int n);
    bit any;
    any = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (cp_req) any = 1'b1;
      cyc();
    end
    chk(name, any, 0);
  endtask

  // Bounded wait for cp_req, then compare against the oldest expectation.
  task automatic take_req(input string name, output logic [1:0] lvl);
    bit seen;
    exp_t e;
    seen = 1'b0;
    lvl = 2'd0;
    for (int i = 0; i < 10; i++) begin
      if (cp_req) begin
        seen = 1'b1;
        break;
      end
      cyc();
    end
    chk({name, "_req_seen"}, seen, 1);
    if (seen) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s_unexpected: got cp_irq %0d want no request",
                 name, cp_irq);
      end else begin
        e = exp_q.pop_front();
        lvl = e.irq;
        chk({name, "_cause"}, cp_cause, e.cause);
        chk({name, "_irq"}, cp_irq, e.irq);
        chk({name, "_addr"}, cp_ret_addr, e.addr);
      end
    end
  endtask

  task automatic grant(input string name, input int dly);
    logic [1:0] lvl;
    take_req(name, lvl);
    repeat (dly) cyc();
    chk({name, "_held"}, cp_req, 1);
    cp_ack = 1'b1;
    cyc();
    cp_ack = 1'b0;
    chk({name, "_flush"}, flush, 1);
    chk({name, "_level"}, level, lvl);
    chk({name, "_req_drop"}, cp_req, 0);
    cyc();
    chk({name, "_flush_1cyc"}, flush, 0);
    chk({name, "_busy"}, busy, 1);
  endtask

  vec_t vt[8];

  initial begin
    vt[0] = '{"irq2",     3'b010, 3'b111, 3'd0, PC_DEF,   2, 1'b1, 2'd2, 2'd0};
    vt[1] = '{"irq1",     3'b001, 3'b111, 3'd0, PC_DEF,   1, 1'b1, 2'd1, 2'd0};
    vt[2] = '{"irq3",     3'b100, 3'b111, 3'd0, PC_DEF,   0, 1'b1, 2'd3, 2'd0};
    vt[3] = '{"prio",     3'b110, 3'b111, 3'd0, PC_DEF,   1, 1'b1, 2'd3, 2'd2};
    vt[4] = '{"masked",   3'b110, 3'b011, 3'd0, PC_DEF,   1, 1'b1, 2'd2, 2'd0};
    vt[5] = '{"allmask",  3'b001, 3'b000, 3'd0, PC_DEF,   1, 1'b0, 2'd0, 2'd0};
    vt[6] = '{"exc5",     3'b000, 3'b111, 3'd5, 32'h80,   3, 1'b1, 2'd3, 2'd0};
    vt[7] = '{"exc_irq",  3'b001, 3'b111, 3'd1, 32'h40,   1, 1'b1, 2'd3, 2'd1};

    do_reset();
    chk("rst_req", cp_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_level", level, 0);
    chk("rst_err", err, 0);
    chk("rst_addr", cp_ret_addr, 0);

    foreach (vt[k]) begin
      do_reset();
      irq_mask = vt[k].mask;
      exc_pc = vt[k].pc;
      exc_cause = vt[k].cause;
      irq_in = vt[k].irq;
      if (vt[k].req)
        push_exp(vt[k].cause, vt[k].exp_irq, vt[k].pc);
      cyc();
      irq_in = 3'b000;
      exc_cause = 3'd0;
      exc_pc = PC_DEF;
      if (vt[k].req) begin
        grant(vt[k].name, vt[k].dly);
        eret_pulse();
        chk({vt[k].name, "_eret_lvl"}, level, 0);
        chk({vt[k].name, "_eret_idle"}, busy, 0);
        if (vt[k].follow != 2'd0) begin
          push_exp(3'd0, vt[k].follow, PC_DEF);
          grant({vt[k].name, "_next"}, 1);
          eret_pulse();
          chk({vt[k].name, "_next_idle"}, busy, 0);
        end else begin
          watch_quiet({vt[k].name, "_no_next"}, 6);
        end
      end else begin
        watch_quiet({vt[k].name, "_no_req"}, 8);
      end
    end

    // Nesting: lower level blocked, higher nests, unwinds in order.
    do_reset();
    push_exp(3'd0, 2'd2, PC_DEF);
    pulse_irq(3'b010);
    grant("nest_a", 1);
    pulse_irq(3'b001);
    watch_quiet("nest_blocked", 6);
    push_exp(3'd0, 2'd3, PC_DEF);
    pulse_irq(3'b100);
    grant("nest_b", 1);
    eret_pulse();
    chk("nest_pop_lvl", level, 2);
    chk("nest_pop_busy", busy, 1);
    eret_pulse();
    chk("nest_pop2_lvl", level, 0);
    chk("nest_pop2_idle", busy, 0);
    push_exp(3'd0, 2'd1, PC_DEF);
    grant("nest_late", 1);
    eret_pulse();

    // Stall holds off the request until the cycle after it falls.
    do_reset();
    stall = 1'b1;
    pulse_irq(3'b100);
    watch_quiet("stall_quiet", 5);
    stall = 1'b0;
    cyc();
    chk("stall_release", cp_req, 1);
    push_exp(3'd0, 2'd3, PC_DEF);
    grant("stall", 0);

    // Ack timeout: request drops after 15 cycles, pending line retried.
    begin
      int n;
      logic [1:0] lvl;
      do_reset();
      push_exp(3'd0, 2'd2, PC_DEF);
      pulse_irq(3'b010);
      take_req("to", lvl);
      n = 0;
      while (cp_req && n < 40) begin
        n++;
        cyc();
      end
      chk("to_len", n, 15);
      chk("to_err", err, 2'b01);
      chk("to_idle", busy, 0);
      cyc();
      chk("to_retry", cp_req, 1);
      chk("to_retry_irq", cp_irq, 2);
    end

    // Stack overflow with five nested exceptions.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      exc_cause = 3'd1;
      exc_pc = 32'h200 + 32'(i);
      push_exp(3'd1, 2'd3, 32'h200 + 32'(i));
      cyc();
      exc_cause = 3'd0;
      exc_pc = PC_DEF;
      grant("ovf", 0);
      if (i == 3) chk("ovf_none_yet", err, 2'b00);
    end
    chk("ovf_err", err, 2'b10);
    for (int i = 0; i < 3; i++) eret_pulse();
    chk("ovf_pop3_busy", busy, 1);
    chk("ovf_pop3_lvl", level, 3);
    eret_pulse();
    chk("ovf_pop4_idle", busy, 0);

    // Reset in the middle of a request.
    do_reset();
    pulse_irq(3'b001);
    chk("rreq_in_req", cp_req, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rreq_req", cp_req, 0);
    chk("rreq_busy", busy, 0);
    chk("rreq_flush", flush, 0);
    chk("rreq_level", level, 0);
    chk("rreq_cause", cp_cause, 0);
    chk("rreq_irq", cp_irq, 0);
    chk("rreq_addr", cp_ret_addr, 0);
    chk("rreq_err", err, 0);
    watch_quiet("rreq_quiet", 4);

    chk("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
